cpu6_memarb: RTL

Single-port memory arbiter that shares one synchronous SRAM between three requesters: the cpu6 data port (loads/stores), the cpu6 instruction fetch port, and a DMA/debug master. It sits between `cpu6_core` and the SoC RAM. It grants at most one access per cycle using fixed priority with a DMA starvation guard and an optional DMA burst lock. It routes 1-cycle-latency read data back to the owning requester.

---
 rtl/cpu6_memarb.sv | 113 +++++++++++
 1 files changed

// File: rtl/cpu6_memarb.sv
// cpu6_memarb: single-port SRAM arbiter for cpu6 data (m0), ifetch (m1) and DMA (m2) masters.
//   clk, reset (async, active-low)
//   mX_req/mX_we/mX_addr/mX_wdata, m2_lock : master requests
//   mX_gnt, mX_rvalid, m_rdata             : grants and routed read data
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : SRAM port
//   m1_stall                               : fetch stall
module cpu6_memarb #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int STARVE_MAX = 4,
   parameter int LOCK_MAX = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m1_req,
   input  logic          m2_req,
   input  logic          m0_we,
   input  logic          m2_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [AW-1:0] m1_addr,
   input  logic [AW-1:0] m2_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic [DW-1:0] m2_wdata,
   input  logic          m2_lock,
   output logic          m0_gnt,
   output logic          m1_gnt,
   output logic          m2_gnt,
   output logic          m0_rvalid,
   output logic          m1_rvalid,
   output logic          m2_rvalid,
   output logic [DW-1:0] m_rdata,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic          m1_stall
);
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);
   localparam logic [7:0] LMAX = 8'(LOCK_MAX);
   typedef enum logic [1:0] {ARB, LOCK, REL} state_t;
   state_t state_q, state_d;
   logic [3:0] starve_q, starve_d;
   logic [7:0] beat_q, beat_d;
   logic rd_pend_q, rd_pend_d;
   logic [1:0] rd_owner_q, rd_owner_d;
   logic g0, g1, g2, arb;
   always_comb begin
      state_d = state_q;
      beat_d = beat_q;
      g0 = 1'b0;
      g1 = 1'b0;
      g2 = 1'b0;
      arb = 1'b0;
      if (state_q == LOCK) begin
         if (m2_req & m2_lock & (beat_q < LMAX)) begin
            g2 = 1'b1;
            beat_d = beat_q + 8'd1;
         end else if (~m2_req | ~m2_lock) begin
            arb = 1'b1;
            state_d = ARB;
         end else
            state_d = REL;
      end else if (state_q == REL) begin
         g0 = m0_req;
         g1 = m1_req & ~m0_req;
         state_d = ARB;
      end else
         arb = 1'b1;
      // starvation guard overrides m0/m1 priority
      if (arb) begin
         g2 = m2_req & ((starve_q == SMAX) | (~m0_req & ~m1_req));
         g0 = m0_req & ~g2;
         g1 = m1_req & ~m0_req & ~g2;
         if (g2 & m2_lock) begin
            state_d = LOCK;
            beat_d = 8'd1;
         end
      end
   end
   // grants are forced low while reset is held
   assign m0_gnt = g0 & reset;
   assign m1_gnt = g1 & reset;
   assign m2_gnt = g2 & reset;
   assign ram_en = m0_gnt | m1_gnt | m2_gnt;
   assign ram_we = (m0_gnt & m0_we) | (m2_gnt & m2_we);
   assign ram_addr = m2_gnt ? m2_addr : m1_gnt ? m1_addr : m0_addr;
   assign ram_wdata = m2_gnt ? m2_wdata : m0_wdata;
   assign m1_stall = m1_req & ~m1_gnt;
   assign starve_d = (m2_req & ~m2_gnt) ? ((starve_q == SMAX) ? starve_q : starve_q + 4'd1) : 4'd0;
   assign rd_pend_d = ram_en & ~ram_we;
   assign rd_owner_d = m2_gnt ? 2'd2 : m1_gnt ? 2'd1 : 2'd0;
   assign m0_rvalid = rd_pend_q & (rd_owner_q == 2'd0);
   assign m1_rvalid = rd_pend_q & (rd_owner_q == 2'd1);
   assign m2_rvalid = rd_pend_q & (rd_owner_q == 2'd2);
   assign m_rdata = ram_rdata;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ARB;
         starve_q <= 4'd0;
         beat_q <= 8'd0;
         rd_pend_q <= 1'b0;
         rd_owner_q <= 2'd0;
      end else begin
         state_q <= state_d;
         starve_q <= starve_d;
         beat_q <= beat_d;
         rd_pend_q <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end
endmodule
